spi_ram_master: RTL and testbench
=================================

Name: spi_ram_master

Overview:
- SPI initiator that drives the SPI slave + RAM wrapper (SS_n/MOSI/MISO) from a simple parallel host request interface.
- Serialises one 10-bit frame per request: 2-bit command plus 8-bit address/data, MSB first.
- For read-data requests, it additionally captures the 8-bit byte the slave returns on MISO.
- Shares the system clock with the slave; there is no separate SCLK. The slave samples MOSI on rising clk and the master samples MISO on rising clk.

Parameters:
- ADDR_SIZE, 8, width of address/data payload field.
- RD_WAIT, 2, clk cycles between the last MOSI bit of a cmd=11 frame and the first MISO bit (slave RAM fetch latency).
- GAP_CYCLES, 1, minimum cycles SS_n is held high between frames (min 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; accepted only when busy=0.
- cmd  input  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- tx_data  input  ADDR_SIZE  address or write data (don't-care bits for cmd=11, sent as 0).
- busy  output  1  high from the accepting edge through the end of the gap.
- done  output  1  one-cycle pulse on the last gap cycle.
- rx_data  output  ADDR_SIZE  byte read from the slave; holds its value until the next cmd=11 completes.
- rx_valid  output  1  one-cycle pulse coincident with done, cmd=11 only.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (async): state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_data=0, counters=0. Reset mid-frame forces SS_n high immediately and aborts the frame with no done pulse.
- Requests are latched on the accepting edge: cmd_r<=cmd, sh_r<={cmd, tx_data} (10 bits). start while busy is ignored.
- FSM states IDLE, SEL, SHIFT, WAIT, RECV, GAP. Registered outputs throughout.
- IDLE: SS_n=1. start -> SEL, busy=1.
- SEL (1 cycle): SS_n=0, MOSI=cmd_r[1]. This is the path-select bit the slave checks in its CHK_CMD state. -> SHIFT.
- SHIFT (ADDR_SIZE+2 cycles): MOSI=sh_r MSB, then shift left each cycle; bit counter counts 0..ADDR_SIZE+1. On the last bit: cmd_r==11 -> WAIT, otherwise -> GAP.
- WAIT (RD_WAIT cycles): SS_n=0, MOSI=0. -> RECV.
- RECV (ADDR_SIZE cycles): SS_n=0. Each rising edge shifts MISO into rx shift register, MSB first. After the last bit, rx_data <= captured byte. -> GAP.
- GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0. On the final cycle, done=1 (and rx_valid=1 if cmd_r==11), then -> IDLE with busy=0.
- Frame length: 1+ADDR_SIZE+2 cycles with SS_n low; cmd=11 adds RD_WAIT+ADDR_SIZE.
- Back-to-back: start asserted in the same cycle busy drops is accepted. Minimum SS_n-high time between frames is GAP_CYCLES+1.
- Protocol ordering is the host's responsibility: the master does not enforce the 00-before-01 or 10-before-11 sequencing.

Decomposition:
- Shared package spi_pkg holds:
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the FSM state enum;
  - the frame width constant FRAME_W = ADDR_SIZE+2.
- One natural sub-module, spi_shift_reg: a parameterised load/shift register with serial in/out, instantiated once for TX and once for RX.
- FSM and counters stay in the top.

Test Plan:
- Write address: start, cmd=00, tx_data=0xC6 -> SS_n low 11 cycles. MOSI=0,0,0,1,1,0,0,0,1,1,0. Then SS_n=1 and done pulse; the slave's internal write address = 198.
- Write data: cmd=01, tx_data=0x8F after the first scenario -> MOSI=0,0,1,1,0,0,0,1,1,1,1; RAM[198]=0x8F.
- Read address then read data: cmd=10, tx_data=0xC6, then cmd=11 against the real slave wrapper -> rx_data=0x8F, rx_valid and done coincide. SS_n stays low 1+10+RD_WAIT+8 cycles during the second frame.
- Busy and back-to-back: start pulsed mid-frame is ignored (no extra frame). start held continuously -> consecutive frames separated by exactly GAP_CYCLES+1 SS_n-high cycles.
- Reset mid-frame: assert rst_n=0 during SHIFT bit 4 -> SS_n=1 and MOSI=0 asynchronously, no done. After release, a new cmd=00 0x55 frame is clean: MOSI=0,0,0,0,1,0,1,0,1,0,1.
- Parameter sweep: RD_WAIT=3 with a behavioural slave returning 0xA5 on MISO -> rx_data=0xA5. A slave aligned one cycle early yields a mismatch, confirming MISO is sampled at the specified cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM initiator:
// command codes, FSM encoding and sizing helpers.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int ADDR_SIZE_DFLT = 8;
  localparam int FRAME_W = ADDR_SIZE_DFLT + 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SEL   = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RECV  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;

  function automatic int frame_w(input int addr_size);
    return addr_size + 2;
  endfunction

  // One counter is shared by every timed state.
  function automatic int cnt_w(input int fw,
                               input int rw,
                               input int gc);
    int m;
    m = fw;
    if (rw > m) m = rw;
    if (gc > m) m = gc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Load/shift register, MSB first, serial input
// entering at the LSB.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_ram_master.sv
// SPI initiator for the SPI slave + RAM wrapper:
// one select bit plus a cmd/payload frame, optional read-back.
module spi_ram_master
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE  = ADDR_SIZE_DFLT,
  parameter int RD_WAIT    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int FW = frame_w(ADDR_SIZE);
  localparam int CW = cnt_w(FW, RD_WAIT, GAP_CYCLES);

  localparam logic [CW-1:0] LAST_SH = CW'(FW - 1);
  localparam logic [CW-1:0] LAST_WT = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] LAST_RX = CW'(ADDR_SIZE - 1);
  localparam logic [CW-1:0] LAST_GP = CW'(GAP_CYCLES - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic ss_n_q, ss_n_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rxv_q, rxv_d;
  logic [ADDR_SIZE-1:0] rxd_q, rxd_d;

  logic tx_load, tx_shift, rx_shift, to_gap;
  logic [FW-1:0] tx_frame, tx_q;
  logic [ADDR_SIZE-1:0] rx_q, rx_nxt;
  logic unused_ok;

  // Payload bits are don't-care for a read-data frame.
  assign tx_frame = {cmd, (cmd == CMD_RD_DATA)
                    ? {ADDR_SIZE{1'b0}} : tx_data};
  assign rx_nxt = {rx_q[ADDR_SIZE-2:0], MISO};
  assign unused_ok = ^{tx_q[FW-2:0], rx_q[ADDR_SIZE-1]};

  spi_shift_reg #(.W(FW)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tx_load),
    .load_val_i(tx_frame),
    .shift_i   (tx_shift),
    .ser_i     (1'b0),
    .q_o       (tx_q)
  );

  spi_shift_reg #(.W(ADDR_SIZE)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (1'b0),
    .load_val_i({ADDR_SIZE{1'b0}}),
    .shift_i   (rx_shift),
    .ser_i     (MISO),
    .q_o       (rx_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    ss_n_d   = ss_n_q;
    mosi_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rxv_d    = 1'b0;
    rxd_d    = rxd_q;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    to_gap   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEL;
          cmd_d   = cmd;
          tx_load = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = cmd[1];
          busy_d  = 1'b1;
        end
      end
      ST_SEL: begin
        state_d  = ST_SHIFT;
        cnt_d    = '0;
        mosi_d   = tx_q[FW-1];
        tx_shift = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_SH) begin
          cnt_d    = cnt_q + 1'b1;
          mosi_d   = tx_q[FW-1];
          tx_shift = 1'b1;
        end else if (cmd_q == CMD_RD_DATA) begin
          cnt_d   = '0;
          state_d = (RD_WAIT == 0) ? ST_RECV : ST_WAIT;
        end else begin
          to_gap = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != LAST_WT) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        if (cnt_q != LAST_RX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          rxd_d  = rx_nxt;
          to_gap = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != LAST_GP) begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_d == LAST_GP);
          rxv_d  = done_d && (cmd_q == CMD_RD_DATA);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // done is registered, so it is raised one edge early.
    if (to_gap) begin
      state_d = ST_GAP;
      cnt_d   = '0;
      ss_n_d  = 1'b1;
      done_d  = (LAST_GP == '0);
      rxv_d   = done_d && (cmd_q == CMD_RD_DATA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural slave+RAM,
// vector table plus corner-case sequences.
module tb_spi_ram_master;
  import spi_pkg::*;

  localparam int RDW  = 2;
  localparam int GAPC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, dsel;
  logic [1:0] cmd;
  logic [7:0] txd;
  logic start1, start3;
  assign start1 = start & ~dsel;
  assign start3 = start & dsel;

  logic busy1, done1, rxv1, ss1, mosi1;
  logic [7:0] rx1;
  logic miso1 = 1'b0;
  logic busy3, done3, rxv3, ss3, mosi3;
  logic [7:0] rx3;
  logic miso3 = 1'b0;

  spi_ram_master #(
    .ADDR_SIZE(8), .RD_WAIT(RDW), .GAP_CYCLES(GAPC)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .cmd(cmd), .tx_data(txd), .busy(busy1),
    .done(done1), .rx_data(rx1), .rx_valid(rxv1),
    .SS_n(ss1), .MOSI(mosi1), .MISO(miso1)
  );

  spi_ram_master #(
    .ADDR_SIZE(8), .RD_WAIT(3), .GAP_CYCLES(1)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .cmd(cmd), .tx_data(txd), .busy(busy3),
    .done(done3), .rx_data(rx3), .rx_valid(rxv3),
    .SS_n(ss3), .MOSI(mosi3), .MISO(miso3)
  );

  logic ss_m, mosi_m, busy_m, done_m, rxv_m;
  logic [7:0] rx_m;
  assign ss_m   = dsel ? ss3   : ss1;
  assign mosi_m = dsel ? mosi3 : mosi1;
  assign busy_m = dsel ? busy3 : busy1;
  assign done_m = dsel ? done3 : done1;
  assign rxv_m  = dsel ? rxv3  : rxv1;
  assign rx_m   = dsel ? rx3   : rx1;

  // Slave + RAM model: select bit, cmd, payload; reads
  // answer RDW cycles after the last MOSI bit.
  int s_bits = 0;
  int s_rd = -1;
  logic [10:0] s_sh = '0;
  logic [7:0] s_wa = '0, s_ra = '0, s_byte = '0;
  logic [7:0] s_ram [256];

  always @(posedge clk) begin
    if (s_rd >= 0) begin
      s_rd = s_rd + 1;
      if (s_rd >= RDW && s_rd < RDW + 8) begin
        miso1 <= s_byte[7 - (s_rd - RDW)];
      end else if (s_rd >= RDW + 8) begin
        miso1 <= 1'b0;
        s_rd = -1;
      end
    end
    if (!ss1 && rst_n) begin
      s_sh = {s_sh[9:0], mosi1};
      s_bits = s_bits + 1;
      if (s_bits == 11) begin
        case (s_sh[9:8])
          2'b00: s_wa = s_sh[7:0];
          2'b01: s_ram[s_wa] = s_sh[7:0];
          2'b10: s_ra = s_sh[7:0];
          default: begin
            s_byte = s_ram[s_ra];
            s_rd = 0;
          end
        endcase
      end
    end else begin
      s_bits = 0;
    end
  end

  // RD_WAIT=3 slave returning 0xA5, optionally one cycle early.
  int l3 = 0;
  int early = 0;
  logic [7:0] b3 = 8'hA5;
  always @(posedge clk) begin
    int k;
    if (!ss3) l3 = l3 + 1;
    else l3 = 0;
    k = l3 - (11 + 3) + early;
    if (k >= 0 && k < 8) miso3 <= b3[7 - k];
    else miso3 <= 1'b0;
  end

  int nfr = 0;
  logic ss_prev = 1'b1;
  always @(negedge clk) begin
    if (ss_prev && !ss1) nfr = nfr + 1;
    ss_prev = ss1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic do_frame(input logic [1:0] c,
                          input logic [7:0] d,
                          output logic [10:0] mos,
                          output int low,
                          output logic rv,
                          output bit got,
                          output logic bsy);
    mos = '0;
    low = 0;
    rv = 1'b0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cmd = c;
    txd = d;
    @(negedge clk);
    start = 1'b0;
    bsy = busy_m;
    for (int i = 0; i < 80 && !got; i++) begin
      if (!ss_m) begin
        if (low < 11) mos = {mos[9:0], mosi_m};
        low++;
      end
      if (done_m) begin
        got = 1'b1;
        rv = rxv_m;
      end
      if (!got) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [7:0]  d;
    logic [10:0] mos;
    int          low;
    logic        rv;
    logic [7:0]  rx;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [10:0] mos;
    int low, n0, hrun, falls;
    logic rv, bsy, phi, dn;
    bit got;

    tbl[0] = '{2'b00, 8'hC6, 11'b00011000110, 11, 1'b0, 8'h00};
    tbl[1] = '{2'b01, 8'h8F, 11'b00110001111, 11, 1'b0, 8'h00};
    tbl[2] = '{2'b10, 8'hC6, 11'b11011000110, 11, 1'b0, 8'h00};
    tbl[3] = '{2'b11, 8'hFF, 11'b11100000000, 21, 1'b1, 8'h8F};
    tbl[4] = '{2'b00, 8'h3A, 11'b00000111010, 11, 1'b0, 8'h8F};
    tbl[5] = '{2'b01, 8'h5C, 11'b00101011100, 11, 1'b0, 8'h8F};
    tbl[6] = '{2'b10, 8'h3A, 11'b11000111010, 11, 1'b0, 8'h8F};
    tbl[7] = '{2'b11, 8'h00, 11'b11100000000, 21, 1'b1, 8'h5C};
    tbl[8] = '{2'b10, 8'hC6, 11'b11011000110, 11, 1'b0, 8'h5C};
    tbl[9] = '{2'b11, 8'h00, 11'b11100000000, 21, 1'b1, 8'h8F};

    rst_n = 1'b0;
    start = 1'b0;
    dsel = 1'b0;
    cmd = '0;
    txd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss", ss1, 1);
    chk("rst_mosi", mosi1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rxv", rxv1, 0);
    chk("rst_rx", rx1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ss", ss1, 1);

    for (int i = 0; i < 10; i++) begin
      do_frame(tbl[i].c, tbl[i].d, mos, low, rv, got, bsy);
      chk($sformatf("v%0d_done", i), got, 1);
      chk($sformatf("v%0d_busy", i), bsy, 1);
      chk($sformatf("v%0d_mosi", i), mos, tbl[i].mos);
      chk($sformatf("v%0d_low", i), low, tbl[i].low);
      chk($sformatf("v%0d_rxv", i), rv, tbl[i].rv);
      chk($sformatf("v%0d_rx", i), rx_m, tbl[i].rx);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i),
          {busy_m, done_m, rxv_m}, 0);
    end
    chk("ram_c6", s_ram[8'hC6], 8'h8F);
    chk("ram_3a", s_ram[8'h3A], 8'h5C);

    // start pulsed mid-frame must not create a second frame
    n0 = nfr;
    @(negedge clk);
    start = 1'b1;
    cmd = CMD_WR_ADDR;
    txd = 8'h12;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    cmd = CMD_WR_DATA;
    txd = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("ign_frames", nfr - n0, 1);
    chk("ign_waddr", s_wa, 8'h12);
    chk("ign_busy", busy1, 0);

    // start held high: frames separated by GAPC+1 high cycles
    @(negedge clk);
    start = 1'b1;
    cmd = CMD_WR_ADDR;
    txd = 8'h01;
    hrun = 0;
    falls = 0;
    phi = 1'b1;
    for (int i = 0; i < 80 && falls < 3; i++) begin
      @(negedge clk);
      if (ss1) begin
        hrun++;
      end else if (phi) begin
        falls++;
        if (falls > 1) chk("b2b_gap", hrun, GAPC + 1);
        hrun = 0;
      end
      phi = ss1;
    end
    start = 1'b0;
    chk("b2b_frames", falls, 3);
    repeat (20) @(negedge clk);
    chk("b2b_idle", busy1, 0);

    // reset during SHIFT bit 4 of a 00/0xAA frame
    @(negedge clk);
    start = 1'b1;
    cmd = CMD_WR_ADDR;
    txd = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_ss", ss1, 0);
    chk("mid_mosi", mosi1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ss", ss1, 1);
    chk("arst_mosi", mosi1, 0);
    chk("arst_busy", busy1, 0);
    dn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done1) dn = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done1) dn = 1'b1;
    end
    chk("arst_nodone", dn, 0);
    do_frame(CMD_WR_ADDR, 8'h55, mos, low, rv, got, bsy);
    chk("post_done", got, 1);
    chk("post_mosi", mos, 11'b00001010101);
    chk("post_low", low, 11);
    chk("post_waddr", s_wa, 8'h55);
    @(negedge clk);

    // RD_WAIT=3 instance, aligned then one cycle early
    dsel = 1'b1;
    early = 0;
    do_frame(CMD_RD_DATA, 8'h00, mos, low, rv, got, bsy);
    chk("rw3_done", got, 1);
    chk("rw3_low", low, 22);
    chk("rw3_rxv", rv, 1);
    chk("rw3_rx", rx_m, 8'hA5);
    @(negedge clk);
    early = 1;
    do_frame(CMD_RD_DATA, 8'h00, mos, low, rv, got, bsy);
    chk("rw3e_done", got, 1);
    chk("rw3e_rx", rx_m, 8'h4A);
    @(negedge clk);
    chk("rw3e_idle", busy_m, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
